multi_ctrl_ws: RTL and testbench

MULTI_CTRL_WS -- requirements
Module: multi_ctrl_ws

---
 rtl/mips_multi_pkg.sv | 55 +++++
 rtl/multi_ctrl_ws_if.sv | 23 ++
 rtl/alu_dec.sv | 35 +++
 rtl/multi_ctrl_ws.sv | 178 +++++++++++++++++
 tb/tb_multi_ctrl_ws.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mips_multi_pkg.sv
// rtl/mips_multi_pkg.sv - states, opcode/func constants, ALU codes and mux encodings for the multicycle controller
package mips_multi_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXE, S_R_WB,
    S_I_EXE, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ERR
  } state_t;

  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_R, CLS_I} alu_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic       ASEL_PC    = 1'b0;
  localparam logic       ASEL_A     = 1'b1;
  localparam logic [1:0] BSEL_B     = 2'b00;
  localparam logic [1:0] BSEL_FOUR  = 2'b01;
  localparam logic [1:0] BSEL_IMM   = 2'b10;
  localparam logic [1:0] BSEL_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] PC_A       = 2'b11;
  localparam logic       ADDR_PC    = 1'b0;
  localparam logic       ADDR_ALUOUT = 1'b1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  function automatic logic r_func_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_OR) || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/multi_ctrl_ws_if.sv
// rtl/multi_ctrl_ws_if.sv - instruction/memory inputs and datapath control outputs of the controller
interface multi_ctrl_ws_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       mem_ready;
  logic       reg_dst, mem_to_reg, reg_write, Mem_or_I, wr31, wrdmux, Asel;
  logic       PCWrite, PCWriteCond, ld_IR, mr, mw;
  logic [1:0] pc_src, Bsel;
  logic [2:0] operation;
  logic [1:0] err;

  modport master (
    input  opcode, func, mem_ready,
    output reg_dst, mem_to_reg, reg_write, Mem_or_I, wr31, wrdmux, Asel,
           PCWrite, PCWriteCond, ld_IR, mr, mw, pc_src, Bsel, operation, err
  );

  modport slave (
    output opcode, func, mem_ready,
    input  reg_dst, mem_to_reg, reg_write, Mem_or_I, wr31, wrdmux, Asel,
           PCWrite, PCWriteCond, ld_IR, mr, mw, pc_src, Bsel, operation, err
  );
endinterface

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - combinational ALU operation decode from state class, opcode and function field
module alu_dec
  import mips_multi_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [2:0] operation
);

  always_comb begin
    operation = ALU_ADD;
    case (cls)
      CLS_SUB: operation = ALU_SUB;
      CLS_R: begin
        case (func)
          FN_SUB:  operation = ALU_SUB;
          FN_AND:  operation = ALU_AND;
          FN_OR:   operation = ALU_OR;
          FN_SLT:  operation = ALU_SLT;
          default: operation = ALU_ADD;
        endcase
      end
      CLS_I: begin
        case (opcode)
          OP_SLTI: operation = ALU_SLT;
          OP_ANDI: operation = ALU_AND;
          default: operation = ALU_ADD;
        endcase
      end
      default: operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_ctrl_ws.sv
// rtl/multi_ctrl_ws.sv - multicycle MIPS control FSM with memory wait-state timeout and sticky error code
module multi_ctrl_ws
  import mips_multi_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  multi_ctrl_ws_if.master bus
);

  // Count of wait cycles already spent; the cycle that would bring it to WAIT_MAX times out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       err_q, err_nxt;
  logic             mem_state, timeout;
  alu_cls_t         cls;
  logic [2:0]       op;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      cnt   <= '0;
      err_q <= ERR_NONE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout   = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    cnt_nxt   = cnt;
    case (state)
      S_FETCH: begin
        if (bus.mem_ready) state_nxt = S_DECODE;
        else if (timeout) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_BUS;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:             state_nxt = S_MEM_ADDR;
          OP_RTYPE:                 state_nxt = (bus.func == FN_JR) ? S_JR : S_R_EXE;
          OP_ADDI, OP_SLTI, OP_ANDI: state_nxt = S_I_EXE;
          OP_BEQ:                   state_nxt = S_BRANCH;
          OP_J:                     state_nxt = S_JUMP;
          OP_JAL:                   state_nxt = S_JAL;
          default: begin
            state_nxt = S_ERR;
            err_nxt   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_nxt = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready) state_nxt = (state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        else if (timeout) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_BUS;
        end
      end
      S_R_EXE: begin
        if (r_func_legal(bus.func)) state_nxt = S_R_WB;
        else begin
          state_nxt = S_ERR;
          err_nxt   = ERR_ILLEGAL;
        end
      end
      S_I_EXE: state_nxt = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_nxt = S_FETCH;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_FETCH;
    endcase
    // Remaining in a memory state only happens while waiting without timeout.
    if (state_nxt != state) cnt_nxt = '0;
    else if (mem_state)     cnt_nxt = cnt + CNT_W'(1);
  end

  always_comb begin
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.Mem_or_I    = ADDR_PC;
    bus.wr31        = 1'b0;
    bus.wrdmux      = 1'b0;
    bus.Asel        = ASEL_PC;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.ld_IR       = 1'b0;
    bus.mr          = 1'b0;
    bus.mw          = 1'b0;
    bus.pc_src      = PC_ALU;
    bus.Bsel        = BSEL_B;
    cls             = CLS_ADD;
    case (state)
      S_FETCH: begin
        bus.mr      = 1'b1;
        bus.Bsel    = BSEL_FOUR;
        bus.ld_IR   = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE:   bus.Bsel = BSEL_IMMSH;
      S_MEM_ADDR: begin
        bus.Asel = ASEL_A;
        bus.Bsel = BSEL_IMM;
      end
      S_MEM_RD: begin
        bus.mr       = 1'b1;
        bus.Mem_or_I = ADDR_ALUOUT;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mw       = 1'b1;
        bus.Mem_or_I = ADDR_ALUOUT;
      end
      S_R_EXE: begin
        bus.Asel = ASEL_A;
        cls      = CLS_R;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_I_EXE: begin
        bus.Asel = ASEL_A;
        bus.Bsel = BSEL_IMM;
        cls      = CLS_I;
      end
      S_I_WB: bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.Asel        = ASEL_A;
        bus.PCWriteCond = 1'b1;
        bus.pc_src      = PC_ALUOUT;
        cls             = CLS_SUB;
      end
      S_JUMP: begin
        bus.PCWrite = 1'b1;
        bus.pc_src  = PC_JUMP;
      end
      S_JR: begin
        bus.PCWrite = 1'b1;
        bus.pc_src  = PC_A;
      end
      S_JAL: begin
        bus.reg_write = 1'b1;
        bus.wr31      = 1'b1;
        bus.wrdmux    = 1'b1;
        bus.PCWrite   = 1'b1;
        bus.pc_src    = PC_JUMP;
      end
      default: ;
    endcase
  end

  alu_dec u_alu_dec (
    .cls       (cls),
    .opcode    (bus.opcode),
    .func      (bus.func),
    .operation (op)
  );

  assign bus.operation = op;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_multi_ctrl_ws.sv
// tb/tb_multi_ctrl_ws.sv - directed cycle-by-cycle bench for multi_ctrl_ws with an output scoreboard
module tb_multi_ctrl_ws;
  import mips_multi_pkg::*;

  localparam int WM = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_ctrl_ws_if bus();

  multi_ctrl_ws #(.WAIT_MAX(WM), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  exp_err = 2'b00;
  logic [20:0] exp_q[$];

  // Expected control word for a state, independent of the design's encoding tables.
  function automatic logic [20:0] model(input state_t st, input logic rdy, input logic [5:0] op,
                                        input logic [5:0] fn, input logic [1:0] e);
    logic rd, mtr, rw, moi, w31, wdm, as, pcw, pcwc, ldir, r, w;
    logic [1:0] pcs, bs;
    logic [2:0] alu;
    {rd, mtr, rw, moi, w31, wdm, as, pcw, pcwc, ldir, r, w} = '0;
    pcs = 2'b00; bs = 2'b00; alu = 3'b010;
    case (st)
      S_FETCH:    begin r = 1; bs = 2'b01; ldir = rdy; pcw = rdy; end
      S_DECODE:   bs = 2'b11;
      S_MEM_ADDR: begin as = 1; bs = 2'b10; end
      S_MEM_RD:   begin r = 1; moi = 1; end
      S_MEM_WB:   begin rw = 1; mtr = 1; end
      S_MEM_WR:   begin w = 1; moi = 1; end
      S_R_EXE: begin
        as = 1;
        case (fn)
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b010;
        endcase
      end
      S_R_WB:     begin rw = 1; rd = 1; end
      S_I_EXE: begin
        as = 1; bs = 2'b10;
        alu = (op == 6'b001010) ? 3'b111 : (op == 6'b001100) ? 3'b000 : 3'b010;
      end
      S_I_WB:     rw = 1;
      S_BRANCH:   begin as = 1; alu = 3'b110; pcwc = 1; pcs = 2'b01; end
      S_JUMP:     begin pcw = 1; pcs = 2'b10; end
      S_JR:       begin pcw = 1; pcs = 2'b11; end
      S_JAL:      begin rw = 1; w31 = 1; wdm = 1; pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {rd, mtr, rw, moi, w31, wdm, as, pcw, pcwc, ldir, r, w, pcs, bs, alu, e};
  endfunction

  task automatic cyc(input string tag, input state_t st, input logic rdy, input logic rst_v);
    logic [20:0] got, want;
    @(negedge clk);
    bus.mem_ready = rdy;
    #1;
    exp_q.push_back(model(st, rdy, bus.opcode, bus.func, exp_err));
    got = {bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.Mem_or_I, bus.wr31, bus.wrdmux, bus.Asel,
           bus.PCWrite, bus.PCWriteCond, bus.ld_IR, bus.mr, bus.mw, bus.pc_src, bus.Bsel,
           bus.operation, bus.err};
    want = exp_q.pop_front();
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
    rst = rst_v;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.func   = fn;
  endtask

  logic [5:0] rfn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [5:0] iop [3] = '{6'b001000, 6'b001010, 6'b001100};

  initial begin
    instr(6'b000000, 6'b000000);
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    cyc("reset_state", S_FETCH, 0, 1);

    instr(6'b100011, 6'b000000);
    cyc("lw_fetch_w1", S_FETCH, 0, 1);
    cyc("lw_fetch_w2", S_FETCH, 0, 1);
    cyc("lw_fetch_rdy", S_FETCH, 1, 1);
    cyc("lw_decode", S_DECODE, 1, 1);
    cyc("lw_addr", S_MEM_ADDR, 1, 1);
    repeat (3) cyc("lw_rd_wait", S_MEM_RD, 0, 1);
    cyc("lw_rd_rdy", S_MEM_RD, 1, 1);
    cyc("lw_wb", S_MEM_WB, 1, 1);

    instr(6'b000100, 6'b000000);
    cyc("beq_fetch", S_FETCH, 1, 1);
    cyc("beq_decode", S_DECODE, 0, 1);
    cyc("beq_branch", S_BRANCH, 1, 1);

    instr(6'b000011, 6'b000000);
    cyc("jal_fetch", S_FETCH, 1, 1);
    cyc("jal_decode", S_DECODE, 0, 1);
    cyc("jal_exec", S_JAL, 0, 1);

    instr(6'b000010, 6'b000000);
    cyc("j_fetch", S_FETCH, 1, 1);
    cyc("j_decode", S_DECODE, 0, 1);
    cyc("j_exec", S_JUMP, 1, 1);

    instr(6'b000000, 6'b001000);
    cyc("jr_fetch", S_FETCH, 1, 1);
    cyc("jr_decode", S_DECODE, 0, 1);
    cyc("jr_exec", S_JR, 0, 1);

    for (int i = 0; i < 5; i++) begin
      instr(6'b000000, rfn[i]);
      cyc("r_fetch", S_FETCH, 1, 1);
      cyc("r_decode", S_DECODE, 0, 1);
      cyc("r_exe", S_R_EXE, 1, 1);
      cyc("r_wb", S_R_WB, 0, 1);
    end

    for (int i = 0; i < 3; i++) begin
      instr(iop[i], 6'b111111);
      cyc("i_fetch", S_FETCH, 1, 1);
      cyc("i_decode", S_DECODE, 0, 1);
      cyc("i_exe", S_I_EXE, 0, 1);
      cyc("i_wb", S_I_WB, 1, 1);
    end

    instr(6'b101011, 6'b000000);
    cyc("sw_fetch", S_FETCH, 1, 1);
    cyc("sw_decode", S_DECODE, 0, 1);
    cyc("sw_addr", S_MEM_ADDR, 0, 1);
    repeat (WM - 1) cyc("sw_wait", S_MEM_WR, 0, 1);
    cyc("sw_rdy_at_limit", S_MEM_WR, 1, 1);

    cyc("swto_fetch", S_FETCH, 1, 1);
    cyc("swto_decode", S_DECODE, 0, 1);
    cyc("swto_addr", S_MEM_ADDR, 0, 1);
    repeat (WM) cyc("swto_wait", S_MEM_WR, 0, 1);
    exp_err = 2'b01;
    cyc("swto_err", S_ERR, 1, 1);
    cyc("swto_err_hold", S_ERR, 1, 0);
    exp_err = 2'b00;

    cyc("fto_after_rst", S_FETCH, 0, 1);
    repeat (WM - 1) cyc("fto_wait", S_FETCH, 0, 1);
    exp_err = 2'b01;
    cyc("fto_err", S_ERR, 0, 0);
    exp_err = 2'b00;

    instr(6'b111111, 6'b000000);
    cyc("ill_op_fetch", S_FETCH, 1, 1);
    cyc("ill_op_decode", S_DECODE, 0, 1);
    exp_err = 2'b10;
    cyc("ill_op_err", S_ERR, 1, 1);
    cyc("ill_op_hold", S_ERR, 0, 0);
    exp_err = 2'b00;

    instr(6'b000000, 6'b000111);
    cyc("ill_fn_fetch", S_FETCH, 1, 1);
    cyc("ill_fn_decode", S_DECODE, 0, 1);
    cyc("ill_fn_exe", S_R_EXE, 0, 1);
    exp_err = 2'b10;
    cyc("ill_fn_err", S_ERR, 0, 0);
    exp_err = 2'b00;

    instr(6'b100011, 6'b000000);
    cyc("rst_lw_fetch", S_FETCH, 1, 1);
    cyc("rst_lw_decode", S_DECODE, 0, 1);
    cyc("rst_lw_addr", S_MEM_ADDR, 0, 1);
    cyc("rst_lw_wait", S_MEM_RD, 0, 1);
    cyc("rst_lw_wait_rst", S_MEM_RD, 0, 0);
    cyc("rst_mid_wait", S_FETCH, 0, 1);
    cyc("rst_then_fetch", S_FETCH, 1, 1);
    cyc("rst_then_decode", S_DECODE, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
